box_drawer: RTL and testbench

BOX_DRAWER -- requirements
Module: box_drawer

---
 rtl/box_drawer.sv | 153 +++++++++++++++
 tb/tb_box_drawer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/box_drawer.sv
// box_drawer: moves a solid rectangle around a VGA framebuffer.
// The block accepts a new top-left position and colour from an upstream
// location processor. It erases the previously drawn box with BG_COLOR and
// then draws the box at the new position, one pixel per clock.
// Pixels that fall off-screen still take a cycle, but they are not plotted.
// All outputs depend only on registered state.
module box_drawer #(
  parameter logic [8:0] BOX_WIDTH     = 9'd10,
  parameter logic [8:0] BOX_HEIGHT    = 9'd48,
  parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
  parameter logic [8:0] SCREEN_HEIGHT = 9'd240,
  parameter logic [2:0] BG_COLOR      = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [8:0] s_x,
  input  logic [8:0] s_y,
  input  logic [2:0] s_color,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] cx_q, cx_d;
  logic [8:0] cy_q, cy_d;
  logic       has_prev_q, has_prev_d;
  logic [8:0] old_x_q, old_x_d;
  logic [8:0] old_y_q, old_y_d;
  logic [8:0] new_x_q, new_x_d;
  logic [8:0] new_y_q, new_y_d;
  logic [2:0] new_c_q, new_c_d;

  logic xfer;
  logic row_end;
  logic last_px;

  // Handshake and scan-position decode shared by the next-state logic.
  always_comb begin
    xfer    = s_valid && (state_q == S_IDLE);
    row_end = (cx_q == BOX_WIDTH - 9'd1);
    last_px = row_end && (cy_q == BOX_HEIGHT - 9'd1);
  end

  // State and datapath registers; reset abandons any sequence in progress.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) stays in the combinational blocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      has_prev_q <= 1'b0;
      old_x_q    <= '0;
      old_y_q    <= '0;
      new_x_q    <= '0;
      new_y_q    <= '0;
      new_c_q    <= '0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      has_prev_q <= has_prev_d;
      old_x_q    <= old_x_d;
      old_y_q    <= old_y_d;
      new_x_q    <= new_x_d;
      new_y_q    <= new_y_d;
      new_c_q    <= new_c_d;
    end
  end

  // Next-state logic. If a box is already on screen, it is erased first.
  always_comb begin
    // NOTE: default every combinational output first so that no path infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer) state_d = has_prev_q ? S_ERASE : S_DRAW;
      S_ERASE: if (last_px) state_d = S_DRAW;
      S_DRAW:  if (last_px) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath update logic:
  //   - capture the position on a transfer;
  //   - scan the box row-major;
  //   - remember the drawn box at the end of a draw.
  always_comb begin
    cx_d       = cx_q;
    cy_d       = cy_q;
    has_prev_d = has_prev_q;
    old_x_d    = old_x_q;
    old_y_d    = old_y_q;
    new_x_d    = new_x_q;
    new_y_d    = new_y_q;
    new_c_d    = new_c_q;
    if (xfer) begin
      new_x_d = s_x;
      new_y_d = s_y;
      new_c_d = s_color;
      cx_d    = '0;
      cy_d    = '0;
    end else if (state_q == S_ERASE || state_q == S_DRAW) begin
      // The counters wrap to zero on the last pixel, so the next phase starts clean.
      if (row_end) begin
        cx_d = '0;
        cy_d = last_px ? 9'd0 : cy_q + 9'd1;
      end else begin
        cx_d = cx_q + 9'd1;
      end
      if (state_q == S_DRAW && last_px) begin
        old_x_d    = new_x_q;
        old_y_d    = new_y_q;
        has_prev_d = 1'b1;
      end
    end
  end

  // Moore output decode. Sums are 10 bits wide so off-screen pixels are clipped correctly.
  always_comb begin
    logic [8:0] base_x;
    logic [8:0] base_y;
    logic [2:0] colour;
    logic [9:0] sum_x;
    logic [9:0] sum_y;
    base_x     = (state_q == S_ERASE) ? old_x_q : new_x_q;
    base_y     = (state_q == S_ERASE) ? old_y_q : new_y_q;
    colour     = (state_q == S_ERASE) ? BG_COLOR : new_c_q;
    sum_x      = {1'b0, base_x} + {1'b0, cx_q};
    sum_y      = {1'b0, base_y} + {1'b0, cy_q};
    s_ready    = (state_q == S_IDLE);
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (state_q == S_ERASE || state_q == S_DRAW) begin
      vga_x      = sum_x[8:0];
      vga_y      = sum_y[7:0];
      vga_colour = colour;
      vga_plot   = (sum_x < {1'b0, SCREEN_WIDTH}) && (sum_y < {1'b0, SCREEN_HEIGHT});
    end
  end

endmodule

// File: tb/tb_box_drawer.sv
// Scoreboard testbench for box_drawer with a 2x2 box.
// Stimulus pushes the expected pixel stream into a queue.
// The monitor pops one entry for every busy cycle and compares it.
module tb_box_drawer;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       p;
  } px_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       s_valid;
  logic       s_ready;
  logic [8:0] s_x;
  logic [8:0] s_y;
  logic [2:0] s_color;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int  total = 0;
  int  bad   = 0;
  px_t exp_q[$];

  box_drawer #(
    .BOX_WIDTH (9'd2),
    .BOX_HEIGHT(9'd2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_x       (s_x),
    .s_y       (s_y),
    .s_color   (s_color),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_px(input int x, input int y, input logic [2:0] c, input logic p);
    px_t e;
    e.x = x[8:0];
    e.y = y[7:0];
    e.c = c;
    e.p = p;
    exp_q.push_back(e);
  endtask

  // Push the four pixels of a 2x2 box, with clipping at 320x240.
  task automatic push_box(input int x, input int y, input logic [2:0] c);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++)
        push_px(x + i, y + j, c, ((x + i) < 320) && ((y + j) < 240));
  endtask

  // Monitor: each busy cycle must match the next expected pixel; idle outputs must be zero.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (s_ready === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_busy: got busy cycle with empty scoreboard (t=%0t)", $time);
        end else begin
          px_t e;
          e = exp_q.pop_front();
          check("pixel{x,y,c,p}", {11'd0, vga_x, vga_y, vga_colour, vga_plot}, {11'd0, e});
        end
      end else begin
        check("idle_outputs", {11'd0, vga_x, vga_y, vga_colour, vga_plot}, 32'd0);
      end
    end
  end

  // Offer one position when the block is ready and hold it for one transfer edge.
  task automatic send(input int x, input int y, input logic [2:0] c);
    int n = 0;
    @(negedge clock);
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got s_ready=%b expected 1", s_ready);
    end
    s_valid = 1'b1;
    s_x     = x[8:0];
    s_y     = y[8:0];
    s_color = c;
    @(posedge clock);
    #1 s_valid = 1'b0;
  endtask

  // Count busy cycles until s_ready is seen high, up to a fixed bound.
  task automatic wait_ready(output int n);
    n = 0;
    forever begin
      @(negedge clock);
      if (s_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: got busy %0d cycles expected fewer", n);
        break;
      end
    end
  endtask

  task automatic finish_frame(input string name, input int exp_busy);
    int n;
    wait_ready(n);
    check(name, n, exp_busy);
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_x     = '0;
    s_y     = '0;
    s_color = '0;
    #1;
    check("rst_plot", vga_plot, 0);
    check("rst_ready", s_ready, 1);
    check("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    #11 reset_n = 1'b1;

    // First box: draw only.
    push_px(10, 20, 3'd4, 1); push_px(11, 20, 3'd4, 1);
    push_px(10, 21, 3'd4, 1); push_px(11, 21, 3'd4, 1);
    send(10, 20, 3'b100);
    finish_frame("first_busy", 4);

    // Move: erase the old box, then draw the new one.
    push_px(10, 20, 3'd0, 1); push_px(11, 20, 3'd0, 1);
    push_px(10, 21, 3'd0, 1); push_px(11, 21, 3'd0, 1);
    push_px(12, 20, 3'd2, 1); push_px(13, 20, 3'd2, 1);
    push_px(12, 21, 3'd2, 1); push_px(13, 21, 3'd2, 1);
    send(12, 20, 3'b010);
    finish_frame("second_busy", 8);

    // Bottom-right corner: only (319,239) is on screen.
    push_px(12, 20, 3'd0, 1); push_px(13, 20, 3'd0, 1);
    push_px(12, 21, 3'd0, 1); push_px(13, 21, 3'd0, 1);
    push_px(319, 239, 3'd7, 1); push_px(320, 239, 3'd7, 0);
    push_px(319, 240, 3'd7, 0); push_px(320, 240, 3'd7, 0);
    send(319, 239, 3'b111);
    finish_frame("corner_busy", 8);

    // s_valid held through busy while s_x changes; one capture per idle window.
    push_px(319, 239, 3'd0, 1); push_px(320, 239, 3'd0, 0);
    push_px(319, 240, 3'd0, 0); push_px(320, 240, 3'd0, 0);
    push_box(30, 40, 3'd1);
    @(negedge clock);
    s_valid = 1'b1; s_x = 9'd30; s_y = 9'd40; s_color = 3'd1;
    @(posedge clock);
    #1 s_x = 9'd50;
    push_box(30, 40, 3'd0);
    push_box(50, 40, 3'd1);
    wait_ready(n);
    check("held_first_busy", n, 8);
    @(posedge clock);
    #1 s_valid = 1'b0;
    finish_frame("held_second_busy", 8);

    // Reset during the third draw pixel abandons the frame.
    push_box(50, 40, 3'd0);
    push_box(60, 70, 3'd5);
    send(60, 70, 3'b101);
    repeat (6) @(posedge clock);
    #1;
    check("pre_reset_px", {vga_x, vga_y, vga_colour, vga_plot}, {9'd60, 8'd71, 3'd5, 1'b1});
    reset_n = 1'b0;
    #1;
    check("midrst_plot", vga_plot, 0);
    check("midrst_ready", s_ready, 1);
    check("midrst_xyc", {vga_x, vga_y, vga_colour}, 0);
    exp_q.delete();
    #2 reset_n = 1'b1;

    // After reset, there is no previous box, so the block draws without erasing.
    push_box(100, 50, 3'd3);
    send(100, 50, 3'b011);
    finish_frame("post_reset_busy", 4);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
